// File: rtl/sta_result_drain.sv
// -----------------------------------------------------------------------------
// sta_result_drain
//
// Drains one row of N systolic-array accumulator results into a W-bit
// valid/ready word stream. When acc_done_i is seen and the block is able to
// capture, all N results are latched into an internal buffer. The PEs are told
// to clear their accumulators on the following cycle, and the buffer is then
// streamed out one word per accepted handshake, lowest PE index first.
//
// A new row can be captured on the same edge that the last word of the
// current row is accepted, so back-to-back rows stream without a bubble.
// A done pulse arriving at any other time during streaming cannot be captured.
// It is dropped and latches the sticky overrun flag.
//
// Parameters
//   N : accumulator results per drain (N >= 2)
//   W : width of each accumulator result
//
// Ports
//   clk_i       : clock, all state updates on rising edge
//   reset_i     : asynchronous active-high reset
//   acc_done_i  : one-cycle pulse, acc_i holds final row results
//   acc_i       : N results from the PE row
//   acc_clear_o : one-cycle pulse telling the PEs to zero their accumulators
//   out_valid_o : stream word valid
//   out_ready_i : downstream accepts the word
//   out_data_o  : current result word (bit-exact copy of the captured value)
//   out_idx_o   : PE index of out_data_o
//   out_last_o  : high with the word of index N-1
//   busy_o      : high while streaming
//   overrun_o   : sticky, a done pulse was dropped
// -----------------------------------------------------------------------------
module sta_result_drain #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 acc_done_i,
    input  logic [W-1:0]         acc_i [N],
    output logic                 acc_clear_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [W-1:0]         out_data_o,
    output logic [$clog2(N)-1:0] out_idx_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       buf_q [N];
    logic               clear_q;
    logic               overrun_q;

    logic               capture;
    logic               overrun_set;
    logic               xfer;
    logic               at_last;

    // ---- control state register ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            clear_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            // The clear pulse follows every capture by exactly one cycle.
            clear_q   <= capture;
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Result buffer carries no reset: it is only ever observed while in
    // STREAM, and reaching STREAM always passes through a capture.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= acc_i[i];
            end
        end
    end

    // ---- next-state and handshake decode ----
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        overrun_set = 1'b0;
        at_last     = (idx_q == LAST_IDX);
        xfer        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // out_ready_i plays no part while idle.
                if (acc_done_i) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                xfer = out_ready_i;
                if (xfer && at_last) begin
                    if (acc_done_i) begin
                        // Recapture on the final handshake: no idle bubble.
                        capture = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (acc_done_i) begin
                        overrun_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ---- outputs, decoded from registers only ----
    always_comb begin
        out_valid_o = (state_q == STREAM);
        busy_o      = (state_q == STREAM);
        out_idx_o   = (state_q == STREAM) ? idx_q : '0;
        out_last_o  = (state_q == STREAM) && at_last;
        out_data_o  = (state_q == STREAM) ? buf_q[idx_q] : '0;
        acc_clear_o = clear_q;
        overrun_o   = overrun_q;
    end

endmodule
